id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Parametrised decode→execute pipeline stage register with a valid/ready handshake, stall, and flush/bubble insertion. Per-operand N-way forwarding mux at capture, plus writeback snooping that refreshes operands while an entry is held stalled. Sits between the decode/regfile read and the ALU, and generalises the fixed fetch/execute register. The hazard unit drives forwarding selects and flush; the execute stage drives backpressure.

## Interface
Parameters:
- XLEN, 32, operand/datapath width
- CTRL_W, 24, width of the opaque control bundle (reg_write, mem_reg, mem_write, alu_src, branch, jal, jalr, itype, funct3, funct7…)
- FWD_SRCS, 2, number of forwarding sources (≥1)
- FWD_SEL_W, $clog2(FWD_SRCS+1), forwarding select width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept
- in_ctrl  in  CTRL_W  control bundle
- in_pc, in_next_pc  in  XLEN  instruction PC / PC+4
- in_imm  in  XLEN  immediate
- in_rs1_data, in_rs2_data  in  XLEN  regfile read data
- in_rs1, in_rs2, in_rd  in  5  register indices
- in_fwd_sel1, in_fwd_sel2  in  FWD_SEL_W  0 = regfile, k = source k
- in_fwd_data  in  FWD_SRCS*XLEN  source k at slice [(k-1)*XLEN +: XLEN]
- in_flush  in  1  kill all held/incoming entries
- wb_en  in  1  writeback occurring this cycle
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- out_valid  out  1  entry valid to execute
- out_ready  in  1  execute accepts
- out_ctrl, out_pc, out_next_pc, out_imm, out_rs1_data, out_rs2_data, out_rs1, out_rs2, out_rd  out  mirror widths  registered entry

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Capture operand: sel 0 → regfile data; 1..FWD_SRCS → that slice; sel > FWD_SRCS → regfile data.
- Snoop: every held entry (main and skid) with valid, wb_en, wb_rd≠0 and wb_rd==rsN replaces rsN_data with wb_data. Applies to both operands independently.
- Capture vs. snoop on the same edge: the captured value wins; snoop acts only on already-held entries.
- Flush: next edge sets out_valid=0, skid cleared, out_ctrl=0, out_rd=0, out_rs1/out_rs2=0; the incoming entry is dropped. Flush has priority over capture, hold and snoop. Data fields other than the above are don't-care when out_valid=0.
- Bubble: out_valid=0 always presents ctrl=0 and rd=0, so downstream sees a NOP with no register write.
- Hold: out_valid & !out_ready keeps all outputs stable except snoop updates.

## Timing
- Reset: every out_* = 0, out_valid = 0, skid empty, in_ready = 1.
- Latency: 1 cycle in→out. Full throughput with out_ready held high.
- Reset deassertion mid-stream: the first accept is possible on the first edge after rst falls.
- Simultaneous accept-in and accept-out: the new entry replaces the old one, with no bubble.

## Configuration
- PIPE_SKID_EN defined: a 2-entry skid buffer is instantiated. in_ready is registered (= !skid_valid), with no combinational path from out_ready. An entry accepted while the main register is stalled goes to the skid and drains to main when out_ready returns. The skid receives snooping.
- Undefined: single register. in_ready = !out_valid | out_ready (combinational).

## Test plan
- Reset → rst pulse mid-stream with out_valid=1 → all outputs 0, out_valid=0, in_ready=1 asynchronously.
- Forwarding → FWD_SRCS=2, in_rs1_data=0x11, slice2=0xAB, sel1=2, sel2=3 → out_rs1_data=0xAB, out_rs2_data=in_rs2_data, one cycle later.
- Stall snoop → hold with out_ready=0, out_rs2=5; pulse wb_en, wb_rd=5, wb_data=0xDEAD → out_rs2_data=0xDEAD next cycle. Repeat with wb_rd=0 → unchanged.
- Flush priority → in_valid=1 and in_flush=1 while holding → next cycle out_valid=0, out_ctrl=0, out_rd=0, and the incoming entry is lost.
- Back-to-back → 8 entries, out_ready=1 → 8 consecutive out_valid cycles, in order, starting 1 cycle after the first.
- Skid (PIPE_SKID_EN) → out_ready=0 for 3 cycles with in_valid=1 → exactly 2 entries held, in_ready=0 after the second. Release → both emerge in order, none dropped or duplicated.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode/execute stage-register signal bundle (upstream, downstream, flush, writeback)
interface id_ex_stage_if #(
    parameter int XLEN      = 32,
    parameter int CTRL_W    = 24,
    parameter int FWD_SRCS  = 2,
    parameter int FWD_SEL_W = $clog2(FWD_SRCS + 1)
);
    logic                     in_valid;
    logic                     in_ready;
    logic [CTRL_W-1:0]        in_ctrl;
    logic [XLEN-1:0]          in_pc;
    logic [XLEN-1:0]          in_next_pc;
    logic [XLEN-1:0]          in_imm;
    logic [XLEN-1:0]          in_rs1_data;
    logic [XLEN-1:0]          in_rs2_data;
    logic [4:0]               in_rs1;
    logic [4:0]               in_rs2;
    logic [4:0]               in_rd;
    logic [FWD_SEL_W-1:0]     in_fwd_sel1;
    logic [FWD_SEL_W-1:0]     in_fwd_sel2;
    logic [FWD_SRCS*XLEN-1:0] in_fwd_data;
    logic                     in_flush;
    logic                     wb_en;
    logic [4:0]               wb_rd;
    logic [XLEN-1:0]          wb_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CTRL_W-1:0]        out_ctrl;
    logic [XLEN-1:0]          out_pc;
    logic [XLEN-1:0]          out_next_pc;
    logic [XLEN-1:0]          out_imm;
    logic [XLEN-1:0]          out_rs1_data;
    logic [XLEN-1:0]          out_rs2_data;
    logic [4:0]               out_rs1;
    logic [4:0]               out_rs2;
    logic [4:0]               out_rd;

    modport slave (
        input  in_valid, in_ctrl, in_pc, in_next_pc, in_imm, in_rs1_data, in_rs2_data,
               in_rs1, in_rs2, in_rd, in_fwd_sel1, in_fwd_sel2, in_fwd_data, in_flush,
               wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_pc, out_next_pc, out_imm,
               out_rs1_data, out_rs2_data, out_rs1, out_rs2, out_rd
    );

    modport master (
        output in_valid, in_ctrl, in_pc, in_next_pc, in_imm, in_rs1_data, in_rs2_data,
               in_rs1, in_rs2, in_rd, in_fwd_sel1, in_fwd_sel2, in_fwd_data, in_flush,
               wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_pc, out_next_pc, out_imm,
               out_rs1_data, out_rs2_data, out_rs1, out_rs2, out_rd
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode->execute stage register with operand forwarding, writeback snoop and flush
// PIPE_SKID_EN adds a skid entry behind the main register and registers in_ready.
module id_ex_stage #(
    parameter int XLEN      = 32,
    parameter int CTRL_W    = 24,
    parameter int FWD_SRCS  = 2,
    parameter int FWD_SEL_W = $clog2(FWD_SRCS + 1)
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   next_pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
    } entry_t;

    entry_t cap;
    entry_t main_q, main_d, main_snp;
    logic   main_valid_q, main_valid_d;
    logic   in_ready;
    logic   in_fire;
    logic   out_fire;

    function automatic entry_t snoop(input entry_t e, input logic held, input logic en,
                                     input logic [4:0] rd, input logic [XLEN-1:0] data);
        entry_t r;
        r = e;
        if (held && en && (rd != 5'd0)) begin
            if (rd == e.rs1) r.rs1_data = data;
            if (rd == e.rs2) r.rs2_data = data;
        end
        return r;
    endfunction

    // An empty slot must look like a NOP downstream: no control bits, no register write.
    function automatic entry_t bubble(input entry_t e);
        entry_t r;
        r      = e;
        r.ctrl = '0;
        r.rd   = '0;
        r.rs1  = '0;
        r.rs2  = '0;
        return r;
    endfunction

    always_comb begin
        cap.ctrl     = bus.in_ctrl;
        cap.pc       = bus.in_pc;
        cap.next_pc  = bus.in_next_pc;
        cap.imm      = bus.in_imm;
        cap.rs1_data = bus.in_rs1_data;
        cap.rs2_data = bus.in_rs2_data;
        cap.rs1      = bus.in_rs1;
        cap.rs2      = bus.in_rs2;
        cap.rd       = bus.in_rd;
        // Out-of-range selects fall through to the regfile value.
        for (int k = 1; k <= FWD_SRCS; k++) begin
            if (bus.in_fwd_sel1 == FWD_SEL_W'(k)) cap.rs1_data = bus.in_fwd_data[(k-1)*XLEN +: XLEN];
            if (bus.in_fwd_sel2 == FWD_SEL_W'(k)) cap.rs2_data = bus.in_fwd_data[(k-1)*XLEN +: XLEN];
        end
    end

    assign out_fire = main_valid_q & bus.out_ready;
    assign in_fire  = bus.in_valid & in_ready;

`ifdef PIPE_SKID_EN
    entry_t skid_q, skid_d, skid_snp;
    logic   skid_valid_q, skid_valid_d;

    assign in_ready = !skid_valid_q;

    always_comb begin
        main_snp     = snoop(main_q, main_valid_q, bus.wb_en, bus.wb_rd, bus.wb_data);
        skid_snp     = snoop(skid_q, skid_valid_q, bus.wb_en, bus.wb_rd, bus.wb_data);
        main_valid_d = main_valid_q;
        main_d       = main_snp;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_snp;
        if (bus.in_flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            skid_d       = '0;
        end else if (skid_valid_q) begin
            if (out_fire) begin
                main_d       = skid_snp;
                skid_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!main_valid_q || out_fire) begin
                main_valid_d = 1'b1;
                main_d       = cap;
            end else begin
                skid_valid_d = 1'b1;
                skid_d       = cap;
            end
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end
        if (!main_valid_d) main_d = bubble(main_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end
`else
    assign in_ready = !main_valid_q | bus.out_ready;

    always_comb begin
        main_snp     = snoop(main_q, main_valid_q, bus.wb_en, bus.wb_rd, bus.wb_data);
        main_valid_d = main_valid_q;
        main_d       = main_snp;
        if (bus.in_flush) begin
            main_valid_d = 1'b0;
        end else if (in_fire) begin
            main_valid_d = 1'b1;
            main_d       = cap;
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end
        if (!main_valid_d) main_d = bubble(main_d);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = main_valid_q;
    assign bus.out_ctrl     = main_q.ctrl;
    assign bus.out_pc       = main_q.pc;
    assign bus.out_next_pc  = main_q.next_pc;
    assign bus.out_imm      = main_q.imm;
    assign bus.out_rs1_data = main_q.rs1_data;
    assign bus.out_rs2_data = main_q.rs2_data;
    assign bus.out_rs1      = main_q.rs1;
    assign bus.out_rs2      = main_q.rs2;
    assign bus.out_rd       = main_q.rd;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage (forwarding, snoop, flush, throughput, skid)
module tb_id_ex_stage;
    localparam int XLEN      = 32;
    localparam int CTRL_W    = 24;
    localparam int FWD_SRCS  = 2;
    localparam int FWD_SEL_W = $clog2(FWD_SRCS + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .FWD_SRCS(FWD_SRCS), .FWD_SEL_W(FWD_SEL_W)) bus ();

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .FWD_SRCS(FWD_SRCS), .FWD_SEL_W(FWD_SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   next_pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   out_count = 0;

    function automatic logic [XLEN-1:0] pick(input logic [FWD_SEL_W-1:0] sel, input logic [XLEN-1:0] rf,
                                            input logic [FWD_SRCS*XLEN-1:0] fwd);
        case (sel)
            2'd1:    return fwd[31:0];
            2'd2:    return fwd[63:32];
            default: return rf;
        endcase
    endfunction

    // Scoreboard: compare on transfer-out, kill on flush, snoop held entries, then record the capture.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (!bus.out_valid) begin
                checks++;
                if (bus.out_ctrl !== '0 || bus.out_rd !== '0) begin
                    errors++;
                    $display("FAIL bubble: ctrl=%h rd=%0d, required ctrl=0 rd=0", bus.out_ctrl, bus.out_rd);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                out_count++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got pc=%h, required no output", bus.out_pc);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_ctrl !== e.ctrl || bus.out_pc !== e.pc || bus.out_next_pc !== e.next_pc ||
                        bus.out_imm !== e.imm || bus.out_rs1_data !== e.rs1_data || bus.out_rs2_data !== e.rs2_data ||
                        bus.out_rs1 !== e.rs1 || bus.out_rs2 !== e.rs2 || bus.out_rd !== e.rd) begin
                        errors++;
                        $display("FAIL sb_entry: got pc=%h ctrl=%h rs1d=%h rs2d=%h rd=%0d, required pc=%h ctrl=%h rs1d=%h rs2d=%h rd=%0d",
                                 bus.out_pc, bus.out_ctrl, bus.out_rs1_data, bus.out_rs2_data, bus.out_rd,
                                 e.pc, e.ctrl, e.rs1_data, e.rs2_data, e.rd);
                    end
                end
            end
            if (bus.in_flush) begin
                sb.delete();
            end else begin
                if (bus.wb_en && bus.wb_rd != 5'd0) begin
                    foreach (sb[i]) begin
                        if (sb[i].rs1 == bus.wb_rd) sb[i].rs1_data = bus.wb_data;
                        if (sb[i].rs2 == bus.wb_rd) sb[i].rs2_data = bus.wb_data;
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    e.ctrl     = bus.in_ctrl;
                    e.pc       = bus.in_pc;
                    e.next_pc  = bus.in_next_pc;
                    e.imm      = bus.in_imm;
                    e.rs1_data = pick(bus.in_fwd_sel1, bus.in_rs1_data, bus.in_fwd_data);
                    e.rs2_data = pick(bus.in_fwd_sel2, bus.in_rs2_data, bus.in_fwd_data);
                    e.rs1      = bus.in_rs1;
                    e.rs2      = bus.in_rs2;
                    e.rd       = bus.in_rd;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_entry(input logic [XLEN-1:0] pc);
        bus.in_ctrl     = CTRL_W'($urandom);
        bus.in_pc       = pc;
        bus.in_next_pc  = pc + 32'd4;
        bus.in_imm      = $urandom;
        bus.in_rs1_data = $urandom;
        bus.in_rs2_data = $urandom;
        bus.in_rs1      = 5'($urandom_range(0, 7));
        bus.in_rs2      = 5'($urandom_range(0, 7));
        bus.in_rd       = 5'($urandom_range(1, 31));
        bus.in_fwd_sel1 = FWD_SEL_W'($urandom_range(0, 3));
        bus.in_fwd_sel2 = FWD_SEL_W'($urandom_range(0, 3));
        bus.in_fwd_data = {$urandom, $urandom};
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_flush  = 1'b0;
        bus.wb_en     = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if ({bus.out_ctrl, bus.out_pc, bus.out_next_pc, bus.out_imm, bus.out_rs1_data, bus.out_rs2_data,
             bus.out_rs1, bus.out_rs2, bus.out_rd} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: pc=%h ctrl=%h rd=%0d, required all zero", bus.out_pc, bus.out_ctrl, bus.out_rd);
        end
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        rand_entry(32'h100);
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100) begin
            errors++;
            $display("FAIL reset_first_accept: out_valid=%b pc=%h, required 1/00000100", bus.out_valid, bus.out_pc);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_pc !== '0 || bus.out_ctrl !== '0 ||
            bus.out_rs1_data !== '0 || bus.out_rd !== '0) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b in_ready=%b pc=%h ctrl=%h, required 0/1/0/0",
                     bus.out_valid, bus.in_ready, bus.out_pc, bus.out_ctrl);
        end
        step();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        step();
    endtask

    task automatic test_forwarding();
        logic [FWD_SEL_W-1:0] s1 [4];
        logic [FWD_SEL_W-1:0] s2 [4];
        logic [XLEN-1:0]      e1 [4];
        logic [XLEN-1:0]      e2 [4];
        s1 = '{2'd2, 2'd1, 2'd0, 2'd3};
        s2 = '{2'd3, 2'd0, 2'd2, 2'd1};
        e1 = '{32'hAB, 32'h55, 32'h11, 32'h11};
        e2 = '{32'h22, 32'h22, 32'hAB, 32'h55};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_entry(32'h200 + 32'(i * 4));
            bus.in_rs1_data = 32'h11;
            bus.in_rs2_data = 32'h22;
            bus.in_fwd_data = {32'hAB, 32'h55};
            bus.in_fwd_sel1 = s1[i];
            bus.in_fwd_sel2 = s2[i];
            bus.in_valid    = 1'b1;
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_rs1_data !== e1[i] || bus.out_rs2_data !== e2[i]) begin
                errors++;
                $display("FAIL fwd_%0d: valid=%b rs1d=%h rs2d=%h, required 1/%h/%h",
                         i, bus.out_valid, bus.out_rs1_data, bus.out_rs2_data, e1[i], e2[i]);
            end
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_stall_snoop();
        bus.out_ready = 1'b0;
        rand_entry(32'h300);
        bus.in_rs1      = 5'd0;
        bus.in_rs2      = 5'd5;
        bus.in_rs1_data = 32'h1111;
        bus.in_rs2_data = 32'h2222;
        bus.in_fwd_sel1 = '0;
        bus.in_fwd_sel2 = '0;
        bus.in_valid    = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b1;
        bus.wb_rd    = 5'd5;
        bus.wb_data  = 32'hDEAD;
        step();
        bus.wb_en = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_rs2_data !== 32'hDEAD || bus.out_rs1_data !== 32'h1111 ||
            bus.out_pc !== 32'h300) begin
            errors++;
            $display("FAIL snoop_hit: valid=%b pc=%h rs1d=%h rs2d=%h, required 1/300/1111/dead",
                     bus.out_valid, bus.out_pc, bus.out_rs1_data, bus.out_rs2_data);
        end
        bus.wb_en   = 1'b1;
        bus.wb_rd   = 5'd0;
        bus.wb_data = 32'hBEEF;
        step();
        bus.wb_en = 1'b0;
        checks++;
        if (bus.out_rs1_data !== 32'h1111 || bus.out_rs2_data !== 32'hDEAD) begin
            errors++;
            $display("FAIL snoop_x0: rs1d=%h rs2d=%h, required 1111/dead", bus.out_rs1_data, bus.out_rs2_data);
        end
        bus.out_ready = 1'b1;
        rand_entry(32'h304);
        bus.in_rs2      = 5'd5;
        bus.in_rs2_data = 32'h77;
        bus.in_fwd_sel2 = '0;
        bus.in_valid    = 1'b1;
        bus.wb_en       = 1'b1;
        bus.wb_rd       = 5'd5;
        bus.wb_data     = 32'h9999;
        step();
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b0;
        checks++;
        if (bus.out_pc !== 32'h304 || bus.out_rs2_data !== 32'h77) begin
            errors++;
            $display("FAIL capture_wins: pc=%h rs2d=%h, required 304/77", bus.out_pc, bus.out_rs2_data);
        end
        step();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        rand_entry(32'h400);
        bus.in_ctrl  = 24'hABCDEF;
        bus.in_rd    = 5'd7;
        bus.in_valid = 1'b1;
        step();
        rand_entry(32'h404);
        bus.in_ctrl = 24'h123456;
        bus.in_rd   = 5'd9;
        step();
        rand_entry(32'h408);
        bus.in_flush = 1'b1;
        step();
        bus.in_flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== '0 || bus.out_rd !== '0 || bus.out_rs1 !== '0 ||
            bus.out_rs2 !== '0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: valid=%b ctrl=%h rd=%0d rs1=%0d rs2=%0d in_ready=%b, required 0/0/0/0/0/1",
                     bus.out_valid, bus.out_ctrl, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        step();
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_lost: out_valid=%b pc=%h, required 0", bus.out_valid, bus.out_pc);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_entry(32'h1000 + 32'(i * 4));
            bus.in_valid = 1'b1;
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h1000 + 32'(i * 4)) begin
                errors++;
                $display("FAIL b2b_%0d: valid=%b pc=%h, required 1/%h", i, bus.out_valid, bus.out_pc,
                         32'h1000 + 32'(i * 4));
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tail: out_valid=%b, required 0", bus.out_valid);
        end
    endtask

`ifdef PIPE_SKID_EN
    task automatic test_skid();
        int base;
        logic ready_seen [3];
        base          = out_count;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_entry(32'h500 + 32'(i * 4));
            bus.in_valid = 1'b1;
            step();
            ready_seen[i] = bus.in_ready;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (ready_seen[0] !== 1'b1 || ready_seen[1] !== 1'b0 || ready_seen[2] !== 1'b0) begin
            errors++;
            $display("FAIL skid_ready: seq=%b%b%b, required 100", ready_seen[0], ready_seen[1], ready_seen[2]);
        end
        checks++;
        if (bus.out_pc !== 32'h500) begin
            errors++;
            $display("FAIL skid_hold: pc=%h, required 500", bus.out_pc);
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h504) begin
            errors++;
            $display("FAIL skid_drain: valid=%b pc=%h, required 1/504", bus.out_valid, bus.out_pc);
        end
        step();
        step();
        checks++;
        if (out_count - base !== 2 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL skid_count: got %0d valid=%b, required 2/0", out_count - base, bus.out_valid);
        end
    endtask
`else
    task automatic test_stall_ready();
        bus.out_ready = 1'b0;
        rand_entry(32'h600);
        bus.in_valid = 1'b1;
        step();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready: in_ready=%b, required 0", bus.in_ready);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: in_ready=%b, required 1", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        step();
        step();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_entry(32'h8000 + 32'(i * 4));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in_flush  = ($urandom_range(0, 29) == 0);
            bus.wb_en     = $urandom_range(0, 1) == 1;
            bus.wb_rd     = 5'($urandom_range(0, 7));
            bus.wb_data   = $urandom;
            step();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: %0d entries outstanding valid=%b, required 0/0", sb.size(), bus.out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rand_entry(32'h0);
        @(posedge clk);
        #2;
        test_reset();
        test_forwarding();
        test_stall_snoop();
        test_flush();
        test_back_to_back();
`ifdef PIPE_SKID_EN
        test_skid();
`else
        test_stall_ready();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
